// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and status signals of the arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              I_Req;
  logic [ADDR_W-1:0] I_Addr;
  logic              I_Ack;
  logic [DATA_W-1:0] I_Rdata;

  logic              D_Req;
  logic              D_We;
  logic [ADDR_W-1:0] D_Addr;
  logic [DATA_W-1:0] D_Wdata;
  logic              D_Ack;
  logic [DATA_W-1:0] D_Rdata;

  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_Writedata;
  logic              Mem_Memread;
  logic              Mem_Memwrite;
  logic [DATA_W-1:0] Mem_Memdata;

  logic              Busy;
  logic              Owner;

  modport slave (
    input  I_Req, I_Addr, D_Req, D_We, D_Addr, D_Wdata, Mem_Memdata,
    output I_Ack, I_Rdata, D_Ack, D_Rdata,
    output Mem_Address, Mem_Writedata, Mem_Memread, Mem_Memwrite,
    output Busy, Owner
  );

  modport master (
    output I_Req, I_Addr, D_Req, D_We, D_Addr, D_Wdata, Mem_Memdata,
    input  I_Ack, I_Rdata, D_Ack, D_Rdata,
    input  Mem_Address, Mem_Writedata, Mem_Memread, Mem_Memwrite,
    input  Busy, Owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between an instruction
// fetch port and a data port; each transaction runs IDLE -> ACCESS -> RESP.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_i_ack;
  logic              r_d_ack;

  logic w_any_req;
  logic w_grant_d;
  logic w_access;

  assign w_any_req = bus.I_Req | bus.D_Req;
  // On a tie the port that did not win last time gets the grant.
  assign w_grant_d = bus.D_Req & (~bus.I_Req | ~r_owner);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_owner <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_ACCESS;
            r_owner <= w_grant_d;
            r_addr  <= w_grant_d ? bus.D_Addr : bus.I_Addr;
            r_wdata <= w_grant_d ? bus.D_Wdata : '0;
            r_we    <= w_grant_d & bus.D_We;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          r_i_ack <= ~r_owner;
          r_d_ack <= r_owner;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
        end
      endcase
    end
  end

  // Memory strobes decode straight from state so an async reset kills them at once.
  assign w_access          = (r_state == S_ACCESS);
  assign bus.Mem_Address   = w_access ? r_addr  : '0;
  assign bus.Mem_Writedata = w_access ? r_wdata : '0;
  assign bus.Mem_Memwrite  = w_access & r_we;
  assign bus.Mem_Memread   = w_access & ~r_we;

  assign bus.I_Ack   = r_i_ack;
  assign bus.D_Ack   = r_d_ack;
  assign bus.I_Rdata = r_i_ack ? bus.Mem_Memdata : '0;
  assign bus.D_Rdata = (r_d_ack & ~r_we) ? bus.Mem_Memdata : '0;

  assign bus.Busy  = (r_state != S_IDLE);
  assign bus.Owner = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter: a transaction-level model
// (shadow memory + last-grantee) predicts grants, strobes, acks and read data.
module tb_mem_arbiter;

  logic Clk;
  logic Reset;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory device with a preload port; read data is registered.
  bit [15:0] mem [65536];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [15:0] pre_data;

  always @(posedge Clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.Mem_Memwrite) mem[bus.Mem_Address] <= bus.Mem_Writedata;
    if (bus.Mem_Memread) bus.Mem_Memdata <= mem[bus.Mem_Address];
  end

  // Reference model state.
  bit [15:0] ref_mem [65536];
  bit        last_owner;
  int        n_checks;
  int        n_fails;
  int        n_txn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit pick_winner(input bit i_req, input bit d_req, input bit last);
    if (i_req && d_req) return ~last;
    return d_req;
  endfunction

  always @(negedge Clk) begin
    check("ack_excl", {31'd0, bus.I_Ack & bus.D_Ack}, 32'd0);
    check("strobe_excl", {31'd0, bus.Mem_Memread & bus.Mem_Memwrite}, 32'd0);
  end

  // Starts at the negedge of an IDLE cycle in which 'port' is the predicted winner;
  // ends at the negedge of the IDLE cycle that follows the response.
  task automatic run_txn(input bit port, input bit [1:0] drop, input bit perturb);
    bit [15:0] e_addr, e_wdata, e_rd;
    bit        e_we;
    if (port == 1'b0) begin
      e_addr = bus.I_Addr; e_we = 1'b0; e_wdata = 16'h0;
    end else begin
      e_addr = bus.D_Addr; e_we = bus.D_We; e_wdata = bus.D_Wdata;
    end

    @(negedge Clk);
    check("acc_busy", {31'd0, bus.Busy}, 32'd1);
    check("acc_owner", {31'd0, bus.Owner}, {31'd0, port});
    check("acc_memread", {31'd0, bus.Mem_Memread}, {31'd0, ~e_we});
    check("acc_memwrite", {31'd0, bus.Mem_Memwrite}, {31'd0, e_we});
    check("acc_addr", {16'd0, bus.Mem_Address}, {16'd0, e_addr});
    check("acc_wdata", {16'd0, bus.Mem_Writedata}, {16'd0, e_wdata});
    check("acc_acks", {30'd0, bus.I_Ack, bus.D_Ack}, 32'd0);
    if (perturb) begin
      if (port == 1'b0) begin
        bus.I_Addr = 16'($urandom_range(0, 255));
      end else begin
        bus.D_Addr  = 16'($urandom_range(0, 255));
        bus.D_We    = 1'($urandom);
        bus.D_Wdata = 16'($urandom);
      end
      #1;
      check("pert_addr", {16'd0, bus.Mem_Address}, {16'd0, e_addr});
      check("pert_memwrite", {31'd0, bus.Mem_Memwrite}, {31'd0, e_we});
      check("pert_wdata", {16'd0, bus.Mem_Writedata}, {16'd0, e_wdata});
    end

    @(negedge Clk);
    e_rd = e_we ? 16'h0 : ref_mem[e_addr];
    if (e_we) ref_mem[e_addr] = e_wdata;
    check("resp_i_ack", {31'd0, bus.I_Ack}, {31'd0, ~port});
    check("resp_d_ack", {31'd0, bus.D_Ack}, {31'd0, port});
    check("resp_i_rdata", {16'd0, bus.I_Rdata}, {16'd0, (port == 1'b0) ? e_rd : 16'h0});
    check("resp_d_rdata", {16'd0, bus.D_Rdata}, {16'd0, (port == 1'b1) ? e_rd : 16'h0});
    check("resp_strobes", {30'd0, bus.Mem_Memread, bus.Mem_Memwrite}, 32'd0);
    check("resp_addr", {16'd0, bus.Mem_Address}, 32'd0);
    check("resp_busy", {31'd0, bus.Busy}, 32'd1);
    last_owner = port;
    n_txn++;
    $display("txn %0d port=%s we=%0d addr=%h wdata=%h rdata=%h", n_txn,
             port ? "D" : "I", e_we, e_addr, e_wdata, e_rd);
    if (drop[0]) bus.I_Req = 1'b0;
    if (drop[1]) bus.D_Req = 1'b0;

    @(negedge Clk);
    check("idle_busy", {31'd0, bus.Busy}, 32'd0);
    check("idle_acks", {30'd0, bus.I_Ack, bus.D_Ack}, 32'd0);
    check("idle_rdata", {bus.I_Rdata, bus.D_Rdata}, 32'd0);
    check("idle_strobes", {30'd0, bus.Mem_Memread, bus.Mem_Memwrite}, 32'd0);
    check("idle_owner", {31'd0, bus.Owner}, {31'd0, port});
  endtask

  initial begin
    bit        w;
    bit [1:0]  sel;
    bit [15:0] d;
    n_checks = 0; n_fails = 0; n_txn = 0;
    Reset = 1'b1;
    pre_we = 1'b0; pre_addr = 16'h0; pre_data = 16'h0;
    bus.I_Req = 1'b0; bus.I_Addr = 16'h0;
    bus.D_Req = 1'b0; bus.D_We = 1'b0; bus.D_Addr = 16'h0; bus.D_Wdata = 16'h0;
    last_owner = 1'b1;

    // Preload while held in reset, checking reset outputs along the way.
    for (int a = 0; a < 256; a++) begin
      @(negedge Clk);
      d = (a == 16) ? 16'hABCD : 16'($urandom);
      pre_we = 1'b1; pre_addr = 16'(a); pre_data = d;
      ref_mem[a] = d;
      if (a % 64 == 0) begin
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_owner", {31'd0, bus.Owner}, 32'd1);
        check("rst_acks", {30'd0, bus.I_Ack, bus.D_Ack}, 32'd0);
        check("rst_mem", {14'd0, bus.Mem_Memread, bus.Mem_Memwrite, bus.Mem_Address}, 32'd0);
      end
    end
    @(negedge Clk);
    pre_we = 1'b0;
    Reset = 1'b0;

    // Fetch alone straight out of reset.
    bus.I_Req = 1'b1; bus.I_Addr = 16'h0010;
    run_txn(1'b0, 2'b01, 1'b0);

    // Data write then read back.
    bus.D_Req = 1'b1; bus.D_We = 1'b1; bus.D_Addr = 16'h1234; bus.D_Wdata = 16'h5A5A;
    run_txn(1'b1, 2'b10, 1'b0);
    bus.D_Req = 1'b1; bus.D_We = 1'b0;
    run_txn(1'b1, 2'b10, 1'b0);
    check("rd_1234_model", {16'd0, ref_mem[16'h1234]}, 32'h5A5A);

    // Both held high: grants alternate I, D, I, D.
    bus.I_Req = 1'b1; bus.I_Addr = 16'h0033;
    bus.D_Req = 1'b1; bus.D_We = 1'b0; bus.D_Addr = 16'h0044;
    run_txn(1'b0, 2'b00, 1'b0);
    run_txn(1'b1, 2'b00, 1'b0);
    run_txn(1'b0, 2'b00, 1'b0);
    run_txn(1'b1, 2'b11, 1'b0);

    // Inputs changed during ACCESS: only the latched write lands.
    bus.D_Req = 1'b1; bus.D_We = 1'b1; bus.D_Addr = 16'h0040; bus.D_Wdata = 16'h1111;
    run_txn(1'b1, 2'b10, 1'b1);
    bus.D_Req = 1'b1; bus.D_We = 1'b0; bus.D_Addr = 16'h0040;
    run_txn(1'b1, 2'b10, 1'b1);

    // Reset during ACCESS of a data write abandons it.
    bus.D_Req = 1'b1; bus.D_We = 1'b1; bus.D_Addr = 16'h0077; bus.D_Wdata = 16'hDEAD;
    @(negedge Clk);
    check("rstacc_memwrite", {31'd0, bus.Mem_Memwrite}, 32'd1);
    Reset = 1'b1;
    #1;
    check("rstacc_drop", {31'd0, bus.Mem_Memwrite}, 32'd0);
    check("rstacc_busy", {31'd0, bus.Busy}, 32'd0);
    check("rstacc_owner", {31'd0, bus.Owner}, 32'd1);
    bus.D_Req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      check("rstacc_no_ack", {31'd0, bus.D_Ack}, 32'd0);
    end
    check("rstacc_mem", {16'd0, mem[16'h0077]}, {16'd0, ref_mem[16'h0077]});
    Reset = 1'b0;
    last_owner = 1'b1;
    bus.I_Req = 1'b1; bus.I_Addr = 16'h0077;
    bus.D_Req = 1'b1; bus.D_We = 1'b0; bus.D_Addr = 16'h0077;
    run_txn(1'b0, 2'b01, 1'b0);
    run_txn(1'b1, 2'b10, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      if (!bus.I_Req && !bus.D_Req) begin
        if ($urandom_range(0, 4) == 0) begin
          @(negedge Clk);
          check("rand_idle_busy", {31'd0, bus.Busy}, 32'd0);
          check("rand_idle_owner", {31'd0, bus.Owner}, {31'd0, last_owner});
          continue;
        end
        sel = 2'($urandom_range(1, 3));
        if (sel[0]) begin
          bus.I_Req = 1'b1; bus.I_Addr = 16'($urandom_range(0, 255));
        end
        if (sel[1]) begin
          bus.D_Req = 1'b1; bus.D_We = 1'($urandom);
          bus.D_Addr = 16'($urandom_range(0, 255)); bus.D_Wdata = 16'($urandom);
        end
      end
      w = pick_winner(bus.I_Req, bus.D_Req, last_owner);
      if ($urandom_range(0, 3) != 0)
        run_txn(w, w ? 2'b10 : 2'b01, $urandom_range(0, 3) == 0);
      else
        run_txn(w, 2'b00, $urandom_range(0, 3) == 0);
    end
    bus.I_Req = 1'b0; bus.D_Req = 1'b0;
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
